// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-master round-robin arbiter for the BRAM data port.
//   Master 0 = core data port, master 1 = AES DMA engine. One read may be
//   outstanding at a time; its response is steered back to the issuing master.
//   A read-return watchdog raises a sticky error and returns zero data.
// Ports:
//   clock, reset          rising-edge clock, synchronous active-low reset
//   mX_read/write/byte_en/address/data_in   master X request
//   mX_ready              request accepted this cycle (combinational)
//   mX_valid/data_out/address_out           master X registered read response
//   mem_read/write/byte_en/address/data_in  request to memory (combinational)
//   mem_data_out/address_out/valid/ready    response / flow control from memory
//   timeout_err           sticky watchdog error
//   perf_grant0/1, perf_conflict            performance counters
// Optional feature: define DMEM_ARB_PERF_EN to build the saturating perf
//   counters; otherwise the perf_* ports are tied to zero.
module dmem_arbiter #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned ADDRESS_BITS   = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      m0_read,
  input  logic                      m0_write,
  input  logic [DATA_WIDTH/8-1:0]   m0_byte_en,
  input  logic [ADDRESS_BITS-1:0]   m0_address,
  input  logic [DATA_WIDTH-1:0]     m0_data_in,
  output logic                      m0_ready,
  output logic                      m0_valid,
  output logic [DATA_WIDTH-1:0]     m0_data_out,
  output logic [ADDRESS_BITS-1:0]   m0_address_out,
  input  logic                      m1_read,
  input  logic                      m1_write,
  input  logic [DATA_WIDTH/8-1:0]   m1_byte_en,
  input  logic [ADDRESS_BITS-1:0]   m1_address,
  input  logic [DATA_WIDTH-1:0]     m1_data_in,
  output logic                      m1_ready,
  output logic                      m1_valid,
  output logic [DATA_WIDTH-1:0]     m1_data_out,
  output logic [ADDRESS_BITS-1:0]   m1_address_out,
  output logic                      mem_read,
  output logic                      mem_write,
  output logic [DATA_WIDTH/8-1:0]   mem_byte_en,
  output logic [ADDRESS_BITS-1:0]   mem_address,
  output logic [DATA_WIDTH-1:0]     mem_data_in,
  input  logic [DATA_WIDTH-1:0]     mem_data_out,
  input  logic [ADDRESS_BITS-1:0]   mem_address_out,
  input  logic                      mem_valid,
  input  logic                      mem_ready,
  output logic                      timeout_err,
  output logic [31:0]               perf_grant0,
  output logic [31:0]               perf_grant1,
  output logic [31:0]               perf_conflict
);

  localparam int unsigned TIMER_W = $clog2(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic {IDLE, RD_WAIT} state_t;

  state_t                    state, state_next;
  logic                      rr_last;
  logic                      owner;
  logic [TIMER_W-1:0]        timer;
  logic [ADDRESS_BITS-1:0]   rd_address;
  logic                      req0, req1;
  logic                      grant, grant_sel, grant_read;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  // State register
  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // Arbitration, memory-side mux and next state
  always_comb begin
    state_next  = state;
    grant       = 1'b0;
    grant_sel   = 1'b0;
    grant_read  = 1'b0;
    m0_ready    = 1'b0;
    m1_ready    = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_byte_en = '0;
    mem_address = '0;
    mem_data_in = '0;
    case (state)
      IDLE: begin
        if (mem_ready && (req0 || req1)) begin
          grant     = 1'b1;
          // On a conflict the master that did not win last time goes first
          grant_sel = (req0 && req1) ? ~rr_last : req1;
          if (grant_sel) begin
            m1_ready    = 1'b1;
            grant_read  = m1_read;
            mem_write   = m1_write & ~m1_read;
            mem_byte_en = m1_byte_en;
            mem_address = m1_address;
            mem_data_in = m1_data_in;
          end else begin
            m0_ready    = 1'b1;
            grant_read  = m0_read;
            mem_write   = m0_write & ~m0_read;
            mem_byte_en = m0_byte_en;
            mem_address = m0_address;
            mem_data_in = m0_data_in;
          end
          mem_read = grant_read;
          if (grant_read) state_next = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (mem_valid || (timer == TIMER_LAST)) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Grant bookkeeping, watchdog and response steering
  always_ff @(posedge clock) begin
    if (!reset) begin
      rr_last        <= 1'b1;
      owner          <= 1'b0;
      timer          <= '0;
      rd_address     <= '0;
      timeout_err    <= 1'b0;
      m0_valid       <= 1'b0;
      m1_valid       <= 1'b0;
      m0_data_out    <= '0;
      m0_address_out <= '0;
      m1_data_out    <= '0;
      m1_address_out <= '0;
    end else begin
      m0_valid <= 1'b0;
      m1_valid <= 1'b0;
      if (grant) begin
        rr_last <= grant_sel;
        if (grant_read) begin
          owner      <= grant_sel;
          timer      <= '0;
          rd_address <= mem_address;
        end
      end
      if (state == RD_WAIT) begin
        if (mem_valid) begin
          if (owner) begin
            m1_valid       <= 1'b1;
            m1_data_out    <= mem_data_out;
            m1_address_out <= mem_address_out;
          end else begin
            m0_valid       <= 1'b1;
            m0_data_out    <= mem_data_out;
            m0_address_out <= mem_address_out;
          end
        end else if (timer == TIMER_LAST) begin
          // Watchdog expiry: return zero data tagged with the issued address
          timeout_err <= 1'b1;
          if (owner) begin
            m1_valid       <= 1'b1;
            m1_data_out    <= '0;
            m1_address_out <= rd_address;
          end else begin
            m0_valid       <= 1'b1;
            m0_data_out    <= '0;
            m0_address_out <= rd_address;
          end
        end else begin
          timer <= timer + TIMER_W'(1);
        end
      end
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic conflict;
  assign conflict = (state == IDLE) && req0 && req1 && mem_ready;

  // Saturating performance counters
  always_ff @(posedge clock) begin
    if (!reset) begin
      perf_grant0   <= '0;
      perf_grant1   <= '0;
      perf_conflict <= '0;
    end else begin
      if (grant && !grant_sel && (perf_grant0 != 32'hFFFF_FFFF))
        perf_grant0 <= perf_grant0 + 32'd1;
      if (grant && grant_sel && (perf_grant1 != 32'hFFFF_FFFF))
        perf_grant1 <= perf_grant1 + 32'd1;
      if (conflict && (perf_conflict != 32'hFFFF_FFFF))
        perf_conflict <= perf_conflict + 32'd1;
    end
  end
`else
  assign perf_grant0   = '0;
  assign perf_grant1   = '0;
  assign perf_conflict = '0;
`endif

endmodule
